// File: rtl/adc_capture_sequencer_pkg.sv
// Shared definitions for the ADC capture sequencer: state encodings and
// the default counter/config width.
package capture_seq_defs;

    localparam int P_CNT_WIDTH_DEFAULT = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FLUSH     = 3'd1;
    localparam logic [2:0] ST_FILL      = 3'd2;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd3;
    localparam logic [2:0] ST_CAPTURE   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FLUSH     = ST_FLUSH,
        S_FILL      = ST_FILL,
        S_WAIT_TRIG = ST_WAIT_TRIG,
        S_CAPTURE   = ST_CAPTURE,
        S_DONE      = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/adc_capture_sequencer_trig_edge_detect.sv
// Trigger event detector: software trigger or an edge of trigger_in in the
// selected direction, reported combinationally in the cycle it occurs.
module trig_edge_detect (
    input  logic clk_adc,
    input  logic reset_n,
    input  logic trigger_in,
    input  logic trigger_level,
    input  logic trigger_now,
    output logic trig_evt
);

    logic trigger_in_r;

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            trigger_in_r <= 1'b0;
        end else begin
            trigger_in_r <= trigger_in;
        end
    end

    // A level already present before the capture is never an edge.
    assign trig_evt = trigger_now ||
                      ((trigger_in != trigger_in_r) && (trigger_in == trigger_level));

endmodule

// File: rtl/adc_capture_sequencer.sv
// Capture sequencer: arm, flush, presample fill, pre-trigger sliding window,
// post-trigger count, done. Drives the sample FIFO write port strobes.
module adc_capture_sequencer
    import capture_seq_defs::*;
#(
    parameter int pCNT_WIDTH = P_CNT_WIDTH_DEFAULT
) (
    input  logic                  clk_adc,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  trigger_in,
    input  logic                  trigger_level,
    input  logic                  trigger_now,
    input  logic [pCNT_WIDTH-1:0] cfg_samples,
    input  logic [pCNT_WIDTH-1:0] cfg_presamples,
    input  logic                  fifo_full,
    output logic                  fifo_flush,
    output logic                  fifo_wr,
    output logic                  fifo_drop,
    output logic                  armed,
    output logic                  capturing,
    output logic                  done,
    output logic                  overflow,
    output logic                  presample_short,
    output logic [pCNT_WIDTH-1:0] sample_count
);

    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);

    seq_state_e            state, state_nxt;
    logic                  arm_r;
    logic                  arm_rise;
    logic                  start_capture;
    logic                  trig_evt;
    logic                  wr_want, drop_want, short_set, ovf_set;
    logic [pCNT_WIDTH-1:0] samples_q, pre_q, pre_clamped, count_after;

    trig_edge_detect u_trig (
        .clk_adc       (clk_adc),
        .reset_n       (reset_n),
        .trigger_in    (trigger_in),
        .trigger_level (trigger_level),
        .trigger_now   (trigger_now),
        .trig_evt      (trig_evt)
    );

    assign arm_rise      = arm && !arm_r;
    assign start_capture = (state == S_IDLE) && arm_rise;

    // At least one post-trigger sample is always kept.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pre_clamped = cfg_presamples;
        if (cfg_samples == '0) begin
            pre_clamped = '0;
        end else if (cfg_presamples >= cfg_samples) begin
            pre_clamped = cfg_samples - CNT_ONE;
        end
    end

    // FIFO occupancy once the write presented this cycle lands.
    always_comb begin
        count_after = sample_count;
        if (fifo_wr && !fifo_drop) begin
            count_after = sample_count + CNT_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_want   = 1'b0;
        drop_want = 1'b0;
        short_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm_rise) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (samples_q == '0) begin
                    state_nxt = S_DONE;
                end else if (pre_q != '0) begin
                    state_nxt = S_FILL;
                    wr_want   = 1'b1;
                end else begin
                    state_nxt = S_WAIT_TRIG;
                end
            end
            S_FILL: begin
                wr_want = 1'b1;
                if (trig_evt) begin
                    state_nxt = S_CAPTURE;
                    short_set = 1'b1;
                end else if (count_after == pre_q) begin
                    state_nxt = S_WAIT_TRIG;
                    drop_want = 1'b1;
                end
            end
            S_WAIT_TRIG: begin
                if (trig_evt) begin
                    state_nxt = S_CAPTURE;
                    wr_want   = 1'b1;
                end else begin
                    wr_want   = (pre_q != '0);
                    drop_want = (pre_q != '0);
                end
            end
            S_CAPTURE: begin
                if (count_after >= samples_q) begin
                    state_nxt = S_DONE;
                end else begin
                    wr_want = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (state != S_IDLE && !arm) begin
            state_nxt = S_IDLE;
            wr_want   = 1'b0;
            drop_want = 1'b0;
            short_set = 1'b0;
        end

        // fifo_wr is registered, so fifo_full is judged in the cycle the next write is scheduled.
        ovf_set = wr_want && fifo_full;
        if (ovf_set) begin
            state_nxt = S_DONE;
            wr_want   = 1'b0;
            drop_want = 1'b0;
        end
    end

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            arm_r           <= 1'b0;
            samples_q       <= '0;
            pre_q           <= '0;
            fifo_flush      <= 1'b0;
            fifo_wr         <= 1'b0;
            fifo_drop       <= 1'b0;
            armed           <= 1'b0;
            capturing       <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            presample_short <= 1'b0;
            sample_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            arm_r      <= arm;
            fifo_flush <= start_capture;
            fifo_wr    <= wr_want;
            fifo_drop  <= drop_want;
            armed      <= (state_nxt == S_FILL) || (state_nxt == S_WAIT_TRIG);
            capturing  <= (state_nxt == S_CAPTURE);
            done       <= (state_nxt == S_DONE);
            if (start_capture) begin
                samples_q       <= cfg_samples;
                pre_q           <= pre_clamped;
                sample_count    <= '0;
                overflow        <= 1'b0;
                presample_short <= 1'b0;
            end else begin
                sample_count <= count_after;
                if (ovf_set)   overflow        <= 1'b1;
                if (short_set) presample_short <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: table of capture scenarios plus
// hand-written overflow, abort/re-arm and ignored-trigger sequences.
module tb_adc_capture_sequencer;

    localparam int W = 32;

    logic         clk_adc = 1'b0;
    logic         reset_n;
    logic         arm, trigger_in, trigger_level, trigger_now, fifo_full;
    logic [W-1:0] cfg_samples, cfg_presamples;
    logic         fifo_flush, fifo_wr, fifo_drop, armed, capturing, done;
    logic         overflow, presample_short;
    logic [W-1:0] sample_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int samples;
        int pre;
        bit level;
        bit init_in;
        int trig_cycle;   // cycle after arm (arm-rise cycle = 0); -1 = none
        bit use_now;
        int exp_writes;
        int exp_drops;
        int exp_count;
        bit exp_short;
        int exp_cap;      // first CAPTURE cycle, -1 = never
        int exp_done;     // first DONE cycle
    } vec_t;

    vec_t vecs[6];

    adc_capture_sequencer #(.pCNT_WIDTH(W)) dut (
        .clk_adc         (clk_adc),
        .reset_n         (reset_n),
        .arm             (arm),
        .trigger_in      (trigger_in),
        .trigger_level   (trigger_level),
        .trigger_now     (trigger_now),
        .cfg_samples     (cfg_samples),
        .cfg_presamples  (cfg_presamples),
        .fifo_full       (fifo_full),
        .fifo_flush      (fifo_flush),
        .fifo_wr         (fifo_wr),
        .fifo_drop       (fifo_drop),
        .armed           (armed),
        .capturing       (capturing),
        .done            (done),
        .overflow        (overflow),
        .presample_short (presample_short),
        .sample_count    (sample_count)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, cap_start, done_cyc, writes, drops, flushes;
        arm            = 1'b0;
        trigger_now    = 1'b0;
        fifo_full      = 1'b0;
        trigger_in     = v.init_in;
        trigger_level  = v.level;
        cfg_samples    = W'(v.samples);
        cfg_presamples = W'(v.pre);
        repeat (3) tick();
        arm = 1'b1;
        cyc = 0; cap_start = -1; done_cyc = -1; writes = 0; drops = 0; flushes = 0;
        while (done_cyc < 0 && cyc < 400) begin
            tick();
            cyc++;
            trigger_now = 1'b0;
            if (fifo_wr) writes++;
            if (fifo_wr && fifo_drop) drops++;
            if (fifo_flush) flushes++;
            if (capturing && cap_start < 0) cap_start = cyc;
            if (done) done_cyc = cyc;
            if (cyc == 5) begin
                cfg_samples    = 3;
                cfg_presamples = 1;
            end
            if (cyc == v.trig_cycle) begin
                if (v.use_now) trigger_now = 1'b1;
                else           trigger_in  = v.level;
            end
        end
        check($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d writes", idx), writes, v.exp_writes);
        check($sformatf("v%0d drops", idx), drops, v.exp_drops);
        check($sformatf("v%0d flush pulses", idx), flushes, 1);
        check($sformatf("v%0d capture start", idx), cap_start, v.exp_cap);
        check($sformatf("v%0d sample_count", idx), sample_count, v.exp_count);
        check($sformatf("v%0d presample_short", idx), presample_short, v.exp_short);
        check($sformatf("v%0d overflow", idx), overflow, 0);
        arm         = 1'b0;
        trigger_now = 1'b0;
        tick();
        check($sformatf("v%0d idle after disarm", idx), {armed, capturing, done, fifo_wr}, 0);
    endtask

    initial begin
        int cyc, done_cyc;
        vecs[0] = '{90,  0, 1'b1, 1'b0, 20, 1'b1,  90,  0, 90, 1'b0, 21, 111};
        vecs[1] = '{90, 10, 1'b1, 1'b0, 50, 1'b0, 129, 39, 90, 1'b0, 51, 131};
        vecs[2] = '{90, 10, 1'b0, 1'b1,  3, 1'b0,  90,  0, 90, 1'b1,  4,  92};
        vecs[3] = '{ 0,  5, 1'b1, 1'b1, -1, 1'b0,   0,  0,  0, 1'b0, -1,   2};
        vecs[4] = '{ 5,  9, 1'b1, 1'b0, 20, 1'b1,  20, 15,  5, 1'b0, 21,  22};
        vecs[5] = '{ 1,  0, 1'b0, 1'b1,  6, 1'b0,   1,  0,  1, 1'b0,  7,   8};

        reset_n = 1'b0; arm = 1'b0; trigger_in = 1'b0; trigger_level = 1'b1;
        trigger_now = 1'b0; fifo_full = 1'b0; cfg_samples = '0; cfg_presamples = '0;
        #12;
        check("reset flags", {fifo_flush, fifo_wr, fifo_drop, armed, capturing, done,
                              overflow, presample_short}, 0);
        check("reset count", sample_count, 0);
        #11 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Overflow: FIFO reports full where the 40th post-trigger write would be scheduled.
        cfg_samples = 90; cfg_presamples = 10; trigger_level = 1'b1; trigger_in = 1'b0;
        repeat (2) tick();
        arm = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            trigger_now = 1'b0;
            fifo_full   = 1'b0;
            if (c == 59) begin
                check("ovf 39th write", fifo_wr, 1);
                check("ovf count before", sample_count, 48);
                fifo_full = 1'b1;
            end
            if (c == 20) trigger_now = 1'b1;
        end
        check("ovf write suppressed", fifo_wr, 0);
        check("ovf flag", overflow, 1);
        check("ovf done", done, 1);
        check("ovf count", sample_count, 49);
        arm = 1'b0;
        tick();
        check("ovf retained in idle", overflow, 1);
        check("ovf idle not done", done, 0);

        // Abort mid-capture after a short presample fill, then re-arm.
        cfg_samples = 90; cfg_presamples = 10; trigger_level = 1'b0; trigger_in = 1'b1;
        repeat (2) tick();
        arm = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1) begin
                check("abort flush pulse", fifo_flush, 1);
                check("abort overflow cleared", overflow, 0);
                check("abort count cleared", sample_count, 0);
            end
            if (c == 3) trigger_in = 1'b0;
            if (c == 20) begin
                check("abort capturing", capturing, 1);
                arm = 1'b0;
            end
        end
        check("abort wr stops", fifo_wr, 0);
        check("abort state idle", {armed, capturing, done}, 0);
        check("abort short retained", presample_short, 1);
        check("abort count retained", sample_count, 19);
        repeat (2) tick();
        trigger_level = 1'b1;
        arm = 1'b1;
        tick();
        check("rearm flush pulse", fifo_flush, 1);
        check("rearm short cleared", presample_short, 0);
        check("rearm count cleared", sample_count, 0);
        tick();
        check("rearm flush one cycle", fifo_flush, 0);
        check("rearm armed", armed, 1);
        arm = 1'b0;
        repeat (2) tick();

        // Held trigger level and a trigger coincident with arm rise are both ignored.
        cfg_samples = 20; cfg_presamples = 4; trigger_level = 1'b1; trigger_in = 1'b1;
        repeat (3) tick();
        arm = 1'b1;
        trigger_now = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            trigger_now = 1'b0;
        end
        check("held level armed", armed, 1);
        check("held level no capture", capturing, 0);
        check("held level window count", sample_count, 4);
        trigger_now = 1'b1;
        cyc = 30; done_cyc = -1;
        while (done_cyc < 0 && cyc < 130) begin
            tick();
            cyc++;
            trigger_now = 1'b0;
            if (cyc == 31) check("late trigger capture", capturing, 1);
            if (done) done_cyc = cyc;
        end
        check("late trigger done cycle", done_cyc, 47);
        check("late trigger count", sample_count, 20);
        arm = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
